hermes_pkt_injector: RTL and testbench
======================================

Name: hermes_pkt_injector

Overview:
- Store-and-forward packetizer that sits directly upstream of the many-core's application injection port (app_src rx/credit/data).
- Collects one packet payload from a valid/ready word stream into an internal buffer and counts the words.
- Once the packet is complete, emits it as a Hermes flit sequence on a credit-based link: target flit, size flit, then payload.
- Replaces file-driven parsers when the source of packets is RTL, for example a host bridge or a traffic generator.

Parameters:
- FLIT_SIZE, 32, width of data flits in bits.
- MAX_PAYLOAD, 64, payload buffer depth in words; must be a power of 2 and ≥2.
- CNT_WIDTH, 16, width of the pkt_count_o counter.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- src_valid_i  input  1  a payload word is offered.
- src_ready_o  output  1  the block accepts the word this cycle.
- src_data_i  input  FLIT_SIZE  payload word.
- src_last_i  input  1  marks the final word of the packet.
- src_target_i  input  16  destination address {x[7:0], y[7:0]}; sampled together with the first word of a packet.
- tx_o  output  1  flit valid toward the NoC.
- credit_i  input  1  the NoC can accept a flit this cycle.
- data_o  output  FLIT_SIZE  flit toward the NoC.
- busy_o  output  1  high in any state other than COLLECT, or when COLLECT holds ≥1 word.
- overflow_o  output  1  sticky; set when a packet is force-closed because the buffer is full.
- pkt_count_o  output  CNT_WIDTH  number of packets fully sent; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values:
  - src_ready_o = 1
  - tx_o = 0
  - data_o = 0
  - busy_o = 0
  - overflow_o = 0
  - pkt_count_o = 0
  - state = COLLECT, word count = 0, read pointer = 0, latched target = 0
- Transfer rules:
  - Source word accepted ⇔ src_valid_i && src_ready_o in the same cycle.
  - Flit consumed ⇔ tx_o && credit_i in the same cycle.
- COLLECT state:
  - src_ready_o = 1, tx_o = 0.
  - Each accepted word is written to buffer[count] and count increments.
  - When count == 0, src_target_i is latched with the word.
  - The packet closes when the accepted word has src_last_i = 1, or when it is written at count == MAX_PAYLOAD-1.
  - If the packet closes on a full buffer without src_last_i, overflow_o is set. The next accepted word starts a new packet with a freshly sampled target.
  - On close, the next state is HEADER, and the stored size equals the number of accepted words (1..MAX_PAYLOAD).
- HEADER state:
  - src_ready_o = 0, tx_o = 1, data_o = zero-extended latched target.
  - On consume, go to SIZE.
- SIZE state:
  - tx_o = 1, data_o = zero-extended size.
  - On consume, go to PAYLOAD with read pointer = 0.
- PAYLOAD state:
  - tx_o = 1, data_o = buffer[rptr].
  - On consume, rptr increments.
  - On consuming the flit at rptr == size-1: pkt_count_o increments, count clears, and the state returns to COLLECT.
  - src_ready_o goes high in the cycle after the last flit is consumed.
- Latency:
  - Closing word accepted at cycle N → header flit presented at N+1.
  - With credit_i held high, the last payload flit is consumed at N+2+size, and a new word can be accepted at N+3+size.
- Output timing:
  - tx_o and data_o derive only from registered state, buffer and pointers; there is no combinational path from credit_i.
  - data_o holds stable while tx_o = 1 and credit_i = 0.
- Backpressure: credit_i low holds the current flit indefinitely, with no loss or duplication.
- Empty input: src_valid_i low in COLLECT leaves all state unchanged; busy_o stays 0 when count == 0.
- Single-word packet: size flit = 1 and exactly 3 flits are emitted.
- Reset mid-operation: the partially collected or partially sent packet is discarded. tx_o is 0 and src_ready_o is 1 in the cycle after rst_i is sampled high. pkt_count_o and overflow_o clear.
- Target width: the target is always 16 bits. Upper FLIT_SIZE-16 bits of the header and size flits are 0.

Test Plan:
- Basic packet:
  - Stimulus: target 0x0102; words 0xA0, 0xA1, 0xA2 (last on 0xA2); credit_i = 1 throughout.
  - Response: flits 0x00000102, 0x00000003, 0xA0, 0xA1, 0xA2 on consecutive cycles starting 1 cycle after last accept; pkt_count_o = 1; then src_ready_o = 1.
- Backpressure:
  - Stimulus: same packet; credit_i toggles 1, 0, 0, 1, …
  - Response: data_o stable during credit-low cycles; exactly 5 flits consumed, in order and without duplication.
- Overflow with MAX_PAYLOAD = 4:
  - Stimulus: 6 words without last, then last on the 6th; target 0x0300.
  - Response: packet 1 has size 4 (words 1–4) and overflow_o = 1; packet 2 has size 2 (words 5–6) and target re-sampled; pkt_count_o = 2.
- Single-word packet:
  - Stimulus: one word 0xDEAD with last, target 0x0000.
  - Response: flits 0x0, 0x1, 0xDEAD.
- Reset mid-packet:
  - Stimulus: assert rst_i after the size flit is consumed.
  - Response: next cycle tx_o = 0, src_ready_o = 1, pkt_count_o = 0; a subsequent packet is emitted correctly.
- Counter wrap with CNT_WIDTH = 2:
  - Stimulus: send 5 one-word packets.
  - Response: pkt_count_o sequence is 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/hermes_pkt_injector.sv
`default_nettype none
// ============================================================================
//  Module      : hermes_pkt_injector
//  Description : Store-and-forward packetizer for a Hermes NoC injection port.
//                Collects one packet payload from a valid/ready word stream
//                into an internal buffer, then emits it on a credit-based
//                link as: target flit, size flit, payload flits.
//
//  Parameters  : FLIT_SIZE   - flit / payload word width in bits (>= 16)
//                MAX_PAYLOAD - payload buffer depth in words (power of 2, >= 2)
//                CNT_WIDTH   - width of the sent-packet counter
//
//  Ports       : clk_i        - clock, rising edge
//                rst_i        - synchronous active-high reset
//                src_valid_i  - payload word offered
//                src_ready_o  - payload word accepted this cycle
//                src_data_i   - payload word
//                src_last_i   - final word of the packet
//                src_target_i - destination {x[7:0], y[7:0]}, taken with
//                               the first word of a packet
//                tx_o         - flit valid toward the NoC
//                credit_i     - NoC accepts a flit this cycle
//                data_o       - flit toward the NoC
//                busy_o       - sending, or holding a partial packet
//                overflow_o   - sticky: a packet was closed on a full buffer
//                pkt_count_o  - packets fully sent, wraps
//
//  Revision    : 1.0 - initial release
// ============================================================================
module hermes_pkt_injector #(
    parameter int FLIT_SIZE   = 32,
    parameter int MAX_PAYLOAD = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [FLIT_SIZE-1:0] src_data_i,
    input  logic                 src_last_i,
    input  logic [15:0]          src_target_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic [CNT_WIDTH-1:0] pkt_count_o
);

    // Pointer width addresses the buffer; the count needs one more bit so a
    // completely full buffer (size == MAX_PAYLOAD) is representable.
    localparam int c_AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int c_CW = c_AW + 1;

    localparam logic [c_CW-1:0]      c_CNT_ONE   = 1;
    localparam logic [c_AW-1:0]      c_PTR_ONE   = 1;
    localparam logic [CNT_WIDTH-1:0] c_PKT_ONE   = 1;
    localparam logic [c_CW-1:0]      c_LAST_SLOT = c_CW'(MAX_PAYLOAD - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HEADER  = 2'd1,
        ST_SIZE    = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [FLIT_SIZE-1:0]  r_buf [MAX_PAYLOAD];
    logic [c_CW-1:0]       r_count;
    logic [c_AW-1:0]       r_rptr;
    logic [15:0]           r_target;
    logic                  r_ovf;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;

    logic                  w_acc;
    logic                  w_close;
    logic                  w_cons;
    logic                  w_rptr_last;

    // Handshakes are derived from the registered state rather than from the
    // output ports so that no output depends on another output.
    assign w_acc       = src_valid_i && (r_state == ST_COLLECT);
    assign w_close     = w_acc && (src_last_i || (r_count == c_LAST_SLOT));
    assign w_cons      = credit_i && (r_state != ST_COLLECT);
    assign w_rptr_last = ({1'b0, r_rptr} == (r_count - c_CNT_ONE));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and link outputs. tx_o/data_o are functions of registered
    // state only; credit_i steers the next state, never the current flit.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        src_ready_o = 1'b0;
        tx_o        = 1'b0;
        data_o      = '0;
        case (r_state)
            ST_COLLECT: begin
                src_ready_o = 1'b1;
                if (w_close) begin
                    w_state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_o   = 1'b1;
                data_o = FLIT_SIZE'(r_target);
                if (credit_i) begin
                    w_state_nxt = ST_SIZE;
                end
            end
            ST_SIZE: begin
                tx_o   = 1'b1;
                data_o = FLIT_SIZE'(r_count);
                if (credit_i) begin
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                tx_o   = 1'b1;
                data_o = r_buf[r_rptr];
                if (credit_i && w_rptr_last) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, pointers and latched header fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count   <= '0;
            r_rptr    <= '0;
            r_target  <= '0;
            r_ovf     <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            if (w_acc) begin
                r_count <= r_count + c_CNT_ONE;
                if (r_count == '0) begin
                    r_target <= src_target_i;
                end
                // Closed because the buffer filled, not because the source
                // ended the packet: the remainder becomes a new packet.
                if (w_close && !src_last_i) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_cons) begin
                case (r_state)
                    ST_SIZE: begin
                        r_rptr <= '0;
                    end
                    ST_PAYLOAD: begin
                        r_rptr <= r_rptr + c_PTR_ONE;
                        if (w_rptr_last) begin
                            r_count   <= '0;
                            r_pkt_cnt <= r_pkt_cnt + c_PKT_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_acc) begin
            r_buf[r_count[c_AW-1:0]] <= src_data_i;
        end
    end

    assign busy_o      = (r_state != ST_COLLECT) || (r_count != '0);
    assign overflow_o  = r_ovf;
    assign pkt_count_o = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hermes_pkt_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hermes_pkt_injector
//  Description : Self-checking bench for hermes_pkt_injector. A word stream is
//                queued, the expected flit sequence is derived from the
//                packetization rules, and the observed link flits are compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hermes_pkt_injector;

    localparam int FLIT_SIZE   = 32;
    localparam int MAX_PAYLOAD = 4;
    localparam int CNT_WIDTH   = 2;
    localparam int BUDGET      = 600;

    logic                 clk;
    logic                 rst_i;
    logic                 src_valid_i;
    logic                 src_ready_o;
    logic [FLIT_SIZE-1:0] src_data_i;
    logic                 src_last_i;
    logic [15:0]          src_target_i;
    logic                 tx_o;
    logic                 credit_i;
    logic [FLIT_SIZE-1:0] data_o;
    logic                 busy_o;
    logic                 overflow_o;
    logic [CNT_WIDTH-1:0] pkt_count_o;

    hermes_pkt_injector #(
        .FLIT_SIZE   (FLIT_SIZE),
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .src_valid_i  (src_valid_i),
        .src_ready_o  (src_ready_o),
        .src_data_i   (src_data_i),
        .src_last_i   (src_last_i),
        .src_target_i (src_target_i),
        .tx_o         (tx_o),
        .credit_i     (credit_i),
        .data_o       (data_o),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o),
        .pkt_count_o  (pkt_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Word stream to offer, and what the link should carry for it
    logic [31:0] w_arr[$];
    bit          l_arr[$];
    logic [15:0] t_arr[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          obs_cyc[$];
    int          last_acc_cyc;
    int          exp_pkts;
    bit          exp_ovf;
    int          model_cnt = 0;
    bit          model_ovf = 1'b0;
    int          wrap_seq[5] = '{1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_stream();
        w_arr.delete(); l_arr.delete(); t_arr.delete();
    endtask

    task automatic add_word(input logic [31:0] w, input bit l, input logic [15:0] t);
        w_arr.push_back(w); l_arr.push_back(l); t_arr.push_back(t);
    endtask

    task automatic add_random_pkt(input int len);
        for (int k = 0; k < len; k++) begin
            add_word($urandom, (k == len - 1), 16'($urandom));
        end
    endtask

    // Packetization rules: a packet ends on a last-marked word or when it
    // reaches MAX_PAYLOAD words; it is sent as target, size, words.
    task automatic build_expected();
        int start;
        start = 0;
        exp_q.delete();
        exp_pkts = 0;
        exp_ovf  = 1'b0;
        for (int k = 0; k < w_arr.size(); k++) begin
            int len;
            len = k - start + 1;
            if (l_arr[k] || len == MAX_PAYLOAD) begin
                if (!l_arr[k]) exp_ovf = 1'b1;
                exp_q.push_back({16'h0000, t_arr[start]});
                exp_q.push_back(32'(len));
                for (int j = start; j <= k; j++) exp_q.push_back(w_arr[j]);
                exp_pkts++;
                start = k + 1;
            end
        end
    endtask

    // Drives the queued words and grants credit (mode 0: always, 1: 1,0,0
    // repeating, 2: random) until exp_n flits have been consumed.
    task automatic run_traffic(input int mode, input int exp_n);
        int  i;
        bit  held;
        bit  done;
        bit  c;
        logic [31:0] hdata;
        i = 0; held = 1'b0; done = 1'b0; hdata = '0;
        obs_q.delete(); obs_cyc.delete(); last_acc_cyc = -1;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(posedge clk); #1;
            if (held) begin
                check("hold_tx", {31'b0, tx_o}, 32'd1);
                check("hold_data", data_o, hdata);
            end
            if (i < w_arr.size()) begin
                src_valid_i  = 1'b1;
                src_data_i   = w_arr[i];
                src_last_i   = l_arr[i];
                src_target_i = t_arr[i];
                if (src_ready_o) begin
                    if (i == w_arr.size() - 1) last_acc_cyc = cyc;
                    i++;
                end
            end else begin
                src_valid_i = 1'b0;
                src_last_i  = 1'b0;
            end
            if (obs_q.size() < exp_n) begin
                case (mode)
                    0:       c = 1'b1;
                    1:       c = (cyc % 3 == 0);
                    default: c = 1'($urandom_range(0, 1));
                endcase
            end else begin
                c = 1'b0;
            end
            credit_i = c;
            if (tx_o && c) begin
                obs_q.push_back(data_o);
                obs_cyc.push_back(cyc);
            end
            held  = tx_o && !c;
            hdata = data_o;
            if (i == w_arr.size() && obs_q.size() == exp_n) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $error("FAIL timeout words_sent=%0d flits_seen=%0d expected_flits=%0d", i, obs_q.size(), exp_n);
        end
        @(posedge clk); #1;
        credit_i    = 1'b0;
        src_valid_i = 1'b0;
        src_last_i  = 1'b0;
    endtask

    task automatic compare_flits(input string tag, input int n);
        check({tag, "_nflits"}, 32'(obs_q.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < obs_q.size()) check($sformatf("%s_flit%0d", tag, k), obs_q[k], exp_q[k]);
        end
    endtask

    // Full-packet run followed by the idle-state checks.
    task automatic run_and_check(input string tag, input int mode);
        build_expected();
        run_traffic(mode, exp_q.size());
        compare_flits(tag, exp_q.size());
        model_cnt = (model_cnt + exp_pkts) % (1 << CNT_WIDTH);
        model_ovf = model_ovf | exp_ovf;
        check({tag, "_pkt_count"}, 32'(pkt_count_o), 32'(model_cnt));
        check({tag, "_overflow"}, {31'b0, overflow_o}, {31'b0, model_ovf});
        check({tag, "_ready_after"}, {31'b0, src_ready_o}, 32'd1);
        check({tag, "_tx_after"}, {31'b0, tx_o}, 32'd0);
        check({tag, "_busy_after"}, {31'b0, busy_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_cnt = 0;
        model_ovf = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; src_valid_i = 1'b0; src_data_i = '0; src_last_i = 1'b0;
        src_target_i = '0; credit_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_ready", {31'b0, src_ready_o}, 32'd1);
        check("rst_tx", {31'b0, tx_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_overflow", {31'b0, overflow_o}, 32'd0);
        check("rst_pkt_count", 32'(pkt_count_o), 32'd0);
        rst_i = 1'b0;

        // Idle input: nothing moves even with credit available
        credit_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("idle_tx", {31'b0, tx_o}, 32'd0);
            check("idle_busy", {31'b0, busy_o}, 32'd0);
        end
        credit_i = 1'b0;

        // Basic packet with full credit, including header latency
        clear_stream();
        add_word(32'hA0, 1'b0, 16'h0102);
        add_word(32'hA1, 1'b0, 16'h0102);
        add_word(32'hA2, 1'b1, 16'h0102);
        run_and_check("basic", 0);
        for (int k = 0; k < 5; k++) begin
            if (k < obs_cyc.size()) check($sformatf("basic_timing%0d", k), 32'(obs_cyc[k]), 32'(last_acc_cyc + 1 + k));
        end
        if (obs_q.size() > 1) begin
            check("basic_hdr_const", obs_q[0], 32'h0000_0102);
            check("basic_size_const", obs_q[1], 32'h0000_0003);
        end

        // Same packet under 1,0,0 credit pattern
        run_and_check("backpressure", 1);

        // Overflow split: 6 words, last on the 6th; 5th word carries a new target
        clear_stream();
        for (int k = 0; k < 6; k++) begin
            add_word($urandom, (k == 5), (k == 4) ? 16'h0455 : 16'h0300);
        end
        run_and_check("overflow", 2);
        if (obs_q.size() == 10) begin
            check("ovf_size1", obs_q[1], 32'd4);
            check("ovf_tgt2", obs_q[6], 32'h0000_0455);
            check("ovf_size2", obs_q[7], 32'd2);
        end

        // Single-word packet
        clear_stream();
        add_word(32'hDEAD, 1'b1, 16'h0000);
        run_and_check("single", 0);

        // Reset after the size flit has been consumed
        clear_stream();
        add_word(32'h11, 1'b0, 16'h0777);
        add_word(32'h22, 1'b0, 16'h0777);
        add_word(32'h33, 1'b1, 16'h0777);
        build_expected();
        run_traffic(0, 2);
        compare_flits("midrst", 2);
        check("midrst_busy_before", {31'b0, busy_o}, 32'd1);
        do_reset();
        check("midrst_tx", {31'b0, tx_o}, 32'd0);
        check("midrst_ready", {31'b0, src_ready_o}, 32'd1);
        check("midrst_pkt_count", 32'(pkt_count_o), 32'd0);
        check("midrst_overflow", {31'b0, overflow_o}, 32'd0);
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        clear_stream();
        add_random_pkt(3);
        run_and_check("after_rst", 2);

        // Counter wrap from a clean reset
        do_reset();
        for (int p = 0; p < 5; p++) begin
            clear_stream();
            add_word($urandom, 1'b1, 16'($urandom));
            run_and_check($sformatf("wrap%0d", p), 0);
            check($sformatf("wrap_seq%0d", p), 32'(pkt_count_o), 32'(wrap_seq[p]));
        end

        // Randomized traffic: lengths span single-word through overflow splits
        for (int b = 0; b < 4; b++) begin
            clear_stream();
            for (int p = 0; p < 5; p++) add_random_pkt($urandom_range(1, 7));
            run_and_check($sformatf("rand%0d", b), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
